simon_stream_ctrl: RTL
======================

# simon_stream_ctrl

Stream controller between the system's block source/sink and the SIMON_64128 core. Buffers incoming 64-bit blocks, performs the core's four-phase newKey/ldKey and newData/ldData/doneData/readData handshakes, and optionally applies CBC chaining. Delivers results through a valid/ready output FIFO. One core per controller; it is the only driver of the core's control inputs.

## Interface

- N, 32: core word width; block is 2N bits.
- M, 4: key words.
- DEPTH, 4: entries in each of the input and output FIFOs (power of two, ≥2).

- clk  in  1  clock; all state updates on posedge.
- R  in  1  asynchronous, active-high reset.
- in_valid / in_ready  in / out  1 / 1  input block handshake.
- in_data  in  2N  input block (plaintext for encrypt, ciphertext for decrypt).
- key_valid / key_ready  in / out  1 / 1  key handshake.
- key_in  in  [M-1:0][N-1:0]  key.
- iv  in  2N  CBC initial vector, sampled with the key.
- mode_cbc, enc_dec_in  in  1 each  CBC enable and direction (1 = encrypt), sampled with the key.
- out_valid / out_ready  out / in  1 / 1  output block handshake.
- out_data  out  2N  result block.
- busy  out  1  high whenever FSM ≠ IDLE or either FIFO is non-empty.
- newKey, newData, readData, enc_dec  out  1 each  to core.
- key  out  [M-1:0][N-1:0]  to core.
- plain  out  2N  to core.
- ldKey, doneKey, ldData, doneData  in  1 each  from core.
- cipher  in  2N  from core.

## Operation

- FSM states: IDLE, KEY_REQ, KEY_WAIT, LOAD, RUN, READ.
- Key acceptance: key_ready = 1 only in IDLE with the input FIFO empty. On key_valid && key_ready, latch key_in into key, latch mode/enc_dec, load chain ← iv, then go to KEY_REQ.
- KEY_REQ: newKey = 1 until ldKey = 1. Then go to KEY_WAIT with newKey = 0.
- KEY_WAIT: wait for doneKey = 1, set key_loaded, return to IDLE.
- IDLE with key_loaded and input FIFO non-empty: pop the head into cur_in and go to LOAD.
- plain source:
  - CBC encrypt: plain = cur_in ^ chain.
  - Otherwise: plain = cur_in.
- LOAD: newData = 1 until ldData = 1. Then go to RUN with newData = 0.
- RUN: wait for doneData = 1 and output FIFO not full. Then push the result, update chain, and go to READ.
- Result value:
  - CBC decrypt: cipher ^ chain.
  - Otherwise: cipher.
- Chain update: CBC encrypt chain ← cipher; CBC decrypt chain ← cur_in; ECB unchanged.
- READ: readData = 1 until doneData = 0. Then go to IDLE with readData = 0.
- All arithmetic is XOR only; widths are exact, with no truncation.

## Timing

- Reset values: all outputs 0, except in_ready = 1 and key_ready = 1. FSM = IDLE, key_loaded = 0, chain = 0, both FIFOs empty.
- Reset mid-operation discards all queued and in-flight blocks. The core must also be reset by the same event.
- FIFO push is on valid && ready.
- in_ready = !full, even if a pop occurs in the same cycle.
- out_valid = !empty; out_data is the head entry, registered.
- A block arriving in an empty input FIFO produces newData = 1 two cycles later: one cycle to the FIFO, one cycle IDLE→LOAD.
- A push at doneData is visible on out_valid the next cycle.
- A full output FIFO stalls in RUN: doneData is held by the core and readData stays 0.
- Key handshake signals and data handshake signals are never asserted in the same cycle.
- A new key is accepted only when the pipeline is drained.

## Structure

- simon_pkg: the block_t (2N) typedef, the key_t typedef, and the state enum.
- Sub-module simon_fifo (parameters W, DEPTH), instantiated twice. Pointers are log2(DEPTH)+1 bits wide with a wrap bit for full/empty.

## Test plan

- Key 1B1A1918_13121110_0B0A0908_03020100, ECB encrypt, input 656B696C20646E75 → output 44C8FC20B9DFA07A. newKey drops one cycle after ldKey.
- ECB decrypt of 44C8FC20B9DFA07A under the same key → 656B696C20646E75.
- Five back-to-back blocks with out_ready = 0 → in_ready falls after the FIFO fills, RUN stalls on the 5th result with readData = 0. Releasing out_ready drains five blocks in order.
- CBC encrypt of three blocks with iv = 0123456789ABCDEF, then CBC decrypt of the outputs with the same iv → original three blocks returned.
- Assert R while in RUN → next cycle all outputs at reset values, FIFOs empty, key_ready = 1.
- key_valid while blocks are queued → key_ready = 0 until all blocks complete.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types for the SIMON stream controller: block/key types and FSM states.
package simon_pkg;

  localparam int SIMON_N = 32;
  localparam int SIMON_M = 4;

  typedef logic [2*SIMON_N-1:0]            block_t;
  typedef logic [SIMON_M-1:0][SIMON_N-1:0] key_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEY_REQ  = 3'd1,
    KEY_WAIT = 3'd2,
    LOAD     = 3'd3,
    RUN      = 3'd4,
    READ     = 3'd5
  } state_t;

endpackage

// File: rtl/simon_stream_ctrl_if.sv
// Block source/sink side of the controller: input blocks, key load, output blocks.
interface simon_stream_ctrl_if #(
  parameter int N = 32,
  parameter int M = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*N-1:0]        in_data;
  logic                  key_valid;
  logic                  key_ready;
  logic [M-1:0][N-1:0]   key_in;
  logic [2*N-1:0]        iv;
  logic                  mode_cbc;
  logic                  enc_dec_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*N-1:0]        out_data;

  modport master (
    output in_valid, in_data, key_valid, key_in, iv, mode_cbc, enc_dec_in, out_ready,
    input  in_ready, key_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, key_valid, key_in, iv, mode_cbc, enc_dec_in, out_ready,
    output in_ready, key_ready, out_valid, out_data
  );
endinterface

// File: rtl/simon_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module simon_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  // Next pointers and storage; overflow/underflow requests are ignored.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (push && !full) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + 1'b1;
    end
    if (pop && !empty) rd_d = rd_q + 1'b1;
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/simon_stream_ctrl.sv
// Stream controller for one SIMON_64128 core: key load handshake, per-block
// newData/ldData/doneData/readData handshake, optional CBC chaining, in/out FIFOs.
module simon_stream_ctrl
  import simon_pkg::*;
#(
  parameter int N     = SIMON_N,
  parameter int M     = SIMON_M,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                R,
  simon_stream_ctrl_if.slave  s,
  output logic                busy,
  output logic                newKey,
  output logic                newData,
  output logic                readData,
  output logic                enc_dec,
  output logic [M-1:0][N-1:0] key,
  output logic [2*N-1:0]      plain,
  input  logic                ldKey,
  input  logic                doneKey,
  input  logic                ldData,
  input  logic                doneData,
  input  logic [2*N-1:0]      cipher
);
  state_t              state_q, state_d;
  logic [M-1:0][N-1:0] key_q, key_d;
  logic                cbc_q, cbc_d, enc_q, enc_d, key_loaded_q, key_loaded_d;
  logic [2*N-1:0]      chain_q, chain_d, cur_in_q, cur_in_d;

  logic                in_pop, in_full, in_empty;
  logic [2*N-1:0]      in_head;
  logic                out_push, out_full, out_empty;
  logic [2*N-1:0]      result;
  logic                cbc_enc, cbc_dec;

  simon_fifo #(.W(2*N), .DEPTH(DEPTH)) u_in_fifo (
    .clk(clk), .rst(R), .push(s.in_valid && s.in_ready), .din(s.in_data),
    .pop(in_pop), .dout(in_head), .full(in_full), .empty(in_empty)
  );

  simon_fifo #(.W(2*N), .DEPTH(DEPTH)) u_out_fifo (
    .clk(clk), .rst(R), .push(out_push), .din(result),
    .pop(s.out_valid && s.out_ready), .dout(s.out_data), .full(out_full), .empty(out_empty)
  );

  assign cbc_enc     = cbc_q && enc_q;
  assign cbc_dec     = cbc_q && !enc_q;
  assign plain       = cbc_enc ? (cur_in_q ^ chain_q) : cur_in_q;
  assign result      = cbc_dec ? (cipher ^ chain_q) : cipher;
  assign key         = key_q;
  assign enc_dec     = enc_q;
  assign s.in_ready  = !in_full;
  assign s.out_valid = !out_empty;
  // A new key may only land once every queued block has gone through the core.
  assign s.key_ready = (state_q == IDLE) && in_empty;
  assign busy        = (state_q != IDLE) || !in_empty || !out_empty;

  // Next-state and core handshake outputs.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    cbc_d        = cbc_q;
    enc_d        = enc_q;
    key_loaded_d = key_loaded_q;
    chain_d      = chain_q;
    cur_in_d     = cur_in_q;
    in_pop       = 1'b0;
    out_push     = 1'b0;
    newKey       = 1'b0;
    newData      = 1'b0;
    readData     = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_loaded_q && !in_empty) begin
          in_pop   = 1'b1;
          cur_in_d = in_head;
          state_d  = LOAD;
        end else if (s.key_valid && s.key_ready) begin
          key_d        = s.key_in;
          cbc_d        = s.mode_cbc;
          enc_d        = s.enc_dec_in;
          chain_d      = s.iv;
          key_loaded_d = 1'b0;
          state_d      = KEY_REQ;
        end
      end
      KEY_REQ: begin
        newKey = 1'b1;
        if (ldKey) state_d = KEY_WAIT;
      end
      KEY_WAIT: begin
        if (doneKey) begin
          key_loaded_d = 1'b1;
          state_d      = IDLE;
        end
      end
      LOAD: begin
        newData = 1'b1;
        if (ldData) state_d = RUN;
      end
      RUN: begin
        // The core holds doneData, so a full output FIFO simply parks us here.
        if (doneData && !out_full) begin
          out_push = 1'b1;
          if (cbc_enc) chain_d = cipher;
          if (cbc_dec) chain_d = cur_in_q;
          state_d = READ;
        end
      end
      READ: begin
        readData = 1'b1;
        if (!doneData) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q      <= IDLE;
      key_q        <= '0;
      cbc_q        <= 1'b0;
      enc_q        <= 1'b0;
      key_loaded_q <= 1'b0;
      chain_q      <= '0;
      cur_in_q     <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      cbc_q        <= cbc_d;
      enc_q        <= enc_d;
      key_loaded_q <= key_loaded_d;
      chain_q      <= chain_d;
      cur_in_q     <= cur_in_d;
    end
  end
endmodule
